// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types, limits and byte-merge helper for the data-memory responder
package riscv_mem_pkg;

    localparam int DMEM_LAT_MAX = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/riscv_dmem_resp_pipe.sv
// rtl/riscv_dmem_resp_pipe.sv - LATENCY-stage response shift register of {valid, we, err, data}
module riscv_dmem_resp_pipe
    import riscv_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_we,
    input  logic        in_err,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic        out_we,
    output logic        out_err,
    output logic [31:0] out_data
);

    logic        valid_q [LATENCY];
    logic        we_q    [LATENCY];
    logic        err_q   [LATENCY];
    logic [31:0] data_q  [LATENCY];

    // Only the valid bits are reset; a reset therefore drops every in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        we_q[0]   <= in_we;
        err_q[0]  <= in_err;
        data_q[0] <= in_data;
        for (int i = 1; i < LATENCY; i++) begin
            we_q[i]   <= we_q[i-1];
            err_q[i]  <= err_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_we    = we_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - word SRAM data-memory target with fixed-latency pipelined responses
// Optional DMEM_ERR_EN: flag misaligned and out-of-range accesses on dmem_err.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    input  logic [3:0]  dmem_be,
    output logic [31:0] dmem_rdata,
    output logic        dmem_valid,
    output logic        dmem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > DMEM_LAT_MAX) begin : g_bad_latency
        $error("riscv_dmem_responder: LATENCY out of range");
    end

    logic [31:0] mem [DEPTH_WORDS];

    dmem_req_t        req;
    dmem_rsp_t        rsp_in;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             access_err;

    assign req    = '{addr: dmem_addr, wdata: dmem_wdata, we: dmem_we, be: dmem_be};
    assign idx    = req.addr[2 +: IDX_W];
    assign accept = dmem_req & ~rst;

`ifdef DMEM_ERR_EN
    assign access_err = (req.addr[1:0] != 2'b00) ||
                        ({1'b0, req.addr} >= (33'(DEPTH_WORDS) << 2));
`else
    // Low and upper address bits are don't-care: the array aliases modulo DEPTH_WORDS.
    logic unused_addr;
    assign unused_addr = ^{req.addr[1:0], req.addr[31:IDX_W+2]};
    assign access_err  = 1'b0;
`endif

    // Write lands at the accepting edge, so a read on the next cycle already sees it.
    always_ff @(posedge clk) begin
        if (accept && req.we && !access_err) begin
            mem[idx] <= be_merge(mem[idx], req.wdata, req.be);
        end
    end

    assign rsp_in.rdata = mem[idx];
    assign rsp_in.err   = access_err;

    logic        pipe_valid;
    logic        pipe_we;
    logic        pipe_err;
    logic [31:0] pipe_data;

    riscv_dmem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_we     (req.we),
        .in_err    (rsp_in.err),
        .in_data   (rsp_in.rdata),
        .out_valid (pipe_valid),
        .out_we    (pipe_we),
        .out_err   (pipe_err),
        .out_data  (pipe_data)
    );

    // Write acks and erroring reads carry zero data; idle cycles are zero as well.
    assign dmem_valid = pipe_valid;
    assign dmem_err   = pipe_valid & pipe_err;
    assign dmem_rdata = (pipe_valid && !pipe_we && !pipe_err) ? pipe_data : 32'h0;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb/tb_riscv_dmem_responder.sv - directed self-checking bench for riscv_dmem_responder at LATENCY 1, 2 and 4
module tb_riscv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [3:0]  dmem_be;

    logic [31:0] rsp_d [3];
    logic        rsp_v [3];
    logic        rsp_e [3];
    int          lats  [3] = '{1, 2, 4};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_rdata(rsp_d[0]), .dmem_valid(rsp_v[0]), .dmem_err(rsp_e[0]));

    riscv_dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_rdata(rsp_d[1]), .dmem_valid(rsp_v[1]), .dmem_err(rsp_e[1]));

    riscv_dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_rdata(rsp_d[2]), .dmem_valid(rsp_v[2]), .dmem_err(rsp_e[2]));

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        dmem_req   = req;
        dmem_we    = we;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        dmem_be    = be;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) cyc();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({rsp_v[k], rsp_e[k], rsp_d[k]} !== 34'h0) begin
                    failures++;
                    $display("FAIL reset_idle lat=%0d cyc=%0d: got v=%b e=%b d=%h, want all zero",
                             lats[k], c, rsp_v[k], rsp_e[k], rsp_d[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        cyc();
        checks++;
        if (rsp_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_t1: got v=%b, want 0", rsp_v[1]);
        end
        drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        cyc();
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL wr_ack_t2: got v=%b e=%b d=%h, want v=1 e=0 d=00000000",
                     rsp_v[1], rsp_e[1], rsp_d[1]);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL rd_after_wr_t3: got v=%b e=%b d=%h, want v=1 e=0 d=deadbeef",
                     rsp_v[1], rsp_e[1], rsp_d[1]);
        end
        cyc();
        checks++;
        if ({rsp_v[1], rsp_d[1]} !== 33'h0) begin
            failures++;
            $display("FAIL wr_rd_t4_idle: got v=%b d=%h, want v=0 d=00000000", rsp_v[1], rsp_d[1]);
        end
    endtask

    task automatic test_partial_write();
        drive(1'b1, 1'b1, 32'h200, 32'h11223344, 4'hF);
        cyc();
        drive(1'b1, 1'b1, 32'h200, 32'hAABBCCDD, 4'b0101);
        cyc();
        drive(1'b1, 1'b1, 32'h200, 32'hFFFFFFFF, 4'b0000);
        cyc();
        drive(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL be0_ack: got v=%b e=%b d=%h, want v=1 e=0 d=00000000",
                     rsp_v[1], rsp_e[1], rsp_d[1]);
        end
        cyc();
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== {1'b1, 1'b0, 32'h11BB33DD}) begin
            failures++;
            $display("FAIL partial_merge: got v=%b e=%b d=%h, want v=1 e=0 d=11bb33dd",
                     rsp_v[1], rsp_e[1], rsp_d[1]);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp;
        int          idx;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'(i * 4), 32'hA0000000 + 32'(i), 4'hF);
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (5) cyc();
        for (int j = 0; j < 14; j++) begin
            for (int k = 0; k < 3; k++) begin
                idx = j - lats[k];
                exp = (idx >= 0 && idx < 8) ? {1'b1, 1'b0, 32'hA0000000 + 32'(idx)} : 34'h0;
                checks++;
                if ({rsp_v[k], rsp_e[k], rsp_d[k]} !== exp) begin
                    failures++;
                    $display("FAIL stream lat=%0d cyc=%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                             lats[k], j, rsp_v[k], rsp_e[k], rsp_d[k], exp[33], exp[32], exp[31:0]);
                end
            end
            drive(j < 8, 1'b0, 32'(j * 4), 32'h0, 4'h0);
            cyc();
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (5) cyc();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        cyc();
        checks++;
        if ({rsp_v[1], rsp_d[1]} !== {1'b1, 32'hA0000000}) begin
            failures++;
            $display("FAIL pre_rst_rsp: got v=%b d=%h, want v=1 d=a0000000", rsp_v[1], rsp_d[1]);
        end
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h40, 32'h0, 4'hF);
        cyc();
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({rsp_v[k], rsp_e[k], rsp_d[k]} !== 34'h0) begin
                    failures++;
                    $display("FAIL rst_drop lat=%0d cyc=%0d: got v=%b e=%b d=%h, want all zero",
                             lats[k], c, rsp_v[k], rsp_e[k], rsp_d[k]);
                end
            end
            if (c == 0) begin
                rst = 1'b0;
                drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            cyc();
        end
        drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== {1'b1, 1'b0, 32'h5A5A5A5A}) begin
            failures++;
            $display("FAIL persist_after_rst: got v=%b e=%b d=%h, want v=1 e=0 d=5a5a5a5a",
                     rsp_v[1], rsp_e[1], rsp_d[1]);
        end
        cyc();
    endtask

    task automatic test_addr_errors();
        logic [33:0] exp_wr;
        logic [33:0] exp_mis;
        logic [33:0] exp_w0;
`ifdef DMEM_ERR_EN
        exp_wr  = {1'b1, 1'b1, 32'h0};
        exp_mis = {1'b1, 1'b1, 32'h0};
        exp_w0  = {1'b1, 1'b0, 32'hA0000000};
`else
        exp_wr  = {1'b1, 1'b0, 32'h0};
        exp_mis = {1'b1, 1'b0, 32'hDEADBEEF};
        exp_w0  = {1'b1, 1'b0, 32'h13579BDF};
`endif
        drive(1'b1, 1'b1, 32'h4000, 32'h13579BDF, 4'hF);
        cyc();
        drive(1'b1, 1'b0, 32'h102, 32'h0, 4'h0);
        cyc();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== exp_wr) begin
            failures++;
            $display("FAIL oor_write_ack: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                     rsp_v[1], rsp_e[1], rsp_d[1], exp_wr[33], exp_wr[32], exp_wr[31:0]);
        end
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== exp_mis) begin
            failures++;
            $display("FAIL misaligned_read: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                     rsp_v[1], rsp_e[1], rsp_d[1], exp_mis[33], exp_mis[32], exp_mis[31:0]);
        end
        cyc();
        checks++;
        if ({rsp_v[1], rsp_e[1], rsp_d[1]} !== exp_w0) begin
            failures++;
            $display("FAIL word0_after_oor: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                     rsp_v[1], rsp_e[1], rsp_d[1], exp_w0[33], exp_w0[32], exp_w0[31:0]);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_reset_inflight();
        test_addr_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
